// File: rtl/dma_axi_bridge.sv
// dma_axi_bridge: converts the DMA engine's read/write burst handshakes into
// an AXI4 master. One read burst and one write burst may be outstanding at a
// time, and the two directions run independently. A new write request is
// accepted only after the B response of the previous write has been seen.
module dma_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // engine read side
  input  logic [31:0]             rd_req_addr,
  input  logic [4:0]              rd_req_len,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  output logic [DATA_WIDTH-1:0]   rd_rdata,
  output logic                    rd_valid,
  output logic                    rd_last,
  input  logic                    rd_ready,
  // engine write side
  input  logic [31:0]             wr_req_addr,
  input  logic [4:0]              wr_req_len,
  input  logic                    wr_req_valid,
  output logic                    wr_req_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  input  logic                    wr_last,
  output logic                    wr_ready,
  // AXI AR
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // AXI R
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  // AXI AW
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // AXI W
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // AXI B
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // sticky error flags
  output logic [2:0]              err_flags,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_t;

  rd_state_t             rd_state, rd_next;
  wr_state_t             wr_state, wr_next;
  logic [ADDR_WIDTH-1:0] ar_addr, aw_addr;
  logic [7:0]            ar_len, aw_len;
  logic [2:0]            beat_cnt;
  logic                  rd_accept, wr_accept, w_beat;
  logic                  rresp_err, bresp_err, wlast_err;

  // burst size and type never change: 4-byte beats, incrementing bursts
  assign m_arsize  = 3'b010;
  assign m_awsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_awburst = 2'b01;
  assign m_araddr  = ar_addr;
  assign m_arlen   = ar_len;
  assign m_awaddr  = aw_addr;
  assign m_awlen   = aw_len;
  assign m_wdata   = wr_data;
  assign m_wstrb   = '1;
  assign rd_rdata  = m_rdata;

  // state registers for both independent FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= R_IDLE;
      wr_state <= W_IDLE;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
    end
  end

  // latch request payloads so AR/AW stay stable until the interconnect accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr  <= '0;
      ar_len   <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      beat_cnt <= '0;
    end else begin
      if (rd_accept) begin
        ar_addr <= ADDR_WIDTH'(rd_req_addr);
        ar_len  <= {3'b000, rd_req_len};
      end
      if (wr_accept) begin
        aw_addr  <= ADDR_WIDTH'(wr_req_addr);
        aw_len   <= {3'b000, wr_req_len};
        beat_cnt <= '0;
      end else if (w_beat) begin
        beat_cnt <= beat_cnt + 3'd1;
      end
    end
  end

  // read FSM next state; R channel is a straight pass-through while in R_DATA
  always_comb begin
    rd_next      = rd_state;
    rd_req_ready = 1'b0;
    rd_accept    = 1'b0;
    m_arvalid    = 1'b0;
    rd_valid     = 1'b0;
    rd_last      = 1'b0;
    m_rready     = 1'b0;
    rresp_err    = 1'b0;
    case (rd_state)
      R_IDLE: begin
        rd_req_ready = ~rst;
        rd_accept    = rd_req_valid & ~rst;
        if (rd_accept) rd_next = R_AR;
      end
      R_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) rd_next = R_DATA;
      end
      R_DATA: begin
        rd_valid = m_rvalid;
        rd_last  = m_rlast;
        m_rready = rd_ready;
        if (m_rvalid && rd_ready) begin
          rresp_err = (m_rresp != 2'b00);
          if (m_rlast) rd_next = R_IDLE;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // write FSM next state; the bridge's own beat counter decides wlast
  always_comb begin
    wr_next      = wr_state;
    wr_req_ready = 1'b0;
    wr_accept    = 1'b0;
    m_awvalid    = 1'b0;
    m_wvalid     = 1'b0;
    wr_ready     = 1'b0;
    m_wlast      = 1'b0;
    m_bready     = 1'b0;
    w_beat       = 1'b0;
    wlast_err    = 1'b0;
    bresp_err    = 1'b0;
    case (wr_state)
      W_IDLE: begin
        wr_req_ready = ~rst;
        wr_accept    = wr_req_valid & ~rst;
        if (wr_accept) wr_next = W_AW;
      end
      W_AW: begin
        m_awvalid = 1'b1;
        if (m_awready) wr_next = W_DATA;
      end
      W_DATA: begin
        m_wvalid = wr_valid;
        wr_ready = m_wready;
        m_wlast  = (beat_cnt == aw_len[2:0]);
        w_beat   = wr_valid & m_wready;
        if (w_beat) begin
          wlast_err = (wr_last != m_wlast);
          if (m_wlast) wr_next = W_RESP;
        end
      end
      W_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          bresp_err = (m_bresp != 2'b00);
          wr_next   = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // sticky error flags; a new error in the clear cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags <= 3'b000;
    end else begin
      err_flags <= (err_clr ? 3'b000 : err_flags) | {wlast_err, bresp_err, rresp_err};
    end
  end

endmodule
